// File: rtl/mult_seq.sv
// Multi-cycle shift-add multiplier: retires K multiplier bits per clock, signed or unsigned.
// Optional accumulate-into-result mode enabled by defining MULT_ACC_EN.
module mult_seq #(
  parameter int unsigned SZ = 32,
  parameter int unsigned K  = 1
) (
  input  logic            clk,
  input  logic            _rst,
  input  logic [SZ-1:0]   a,
  input  logic [SZ-1:0]   b,
  input  logic            sgn,
  input  logic            start,
`ifdef MULT_ACC_EN
  input  logic            acc,
`endif
  output logic [2*SZ-1:0] res,
  output logic            ready,
  output logic            done
);

  localparam int unsigned STEPS = SZ / K;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (SZ % K != 0) begin : g_chk
    $error("mult_seq: SZ must be a multiple of K");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q;
  logic [SZ-1:0]     mag_a_q;
  logic [2*SZ-1:0]   mag_b_q;
  logic [2*SZ-1:0]   acc_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q;
  logic [2*SZ-1:0]   res_q;
  logic              ready_q;
  logic              done_q;
`ifdef MULT_ACC_EN
  logic              accm_q;
`endif

  // Magnitudes: the most negative value maps to 2^(SZ-1), which still fits unsigned.
  logic [SZ-1:0]     mag_a_d, mag_b_d;
  logic [2*SZ-1:0]   pp_d, prod_d, res_d;

  assign mag_a_d = (sgn && a[SZ-1]) ? -a : a;
  assign mag_b_d = (sgn && b[SZ-1]) ? -b : b;
  assign pp_d    = mag_b_q * {{(2*SZ-K){1'b0}}, mag_a_q[K-1:0]};
  assign prod_d  = neg_q ? -acc_q : acc_q;
`ifdef MULT_ACC_EN
  assign res_d   = accm_q ? res_q + prod_d : prod_d;
`else
  assign res_d   = prod_d;
`endif

  always_ff @(posedge clk) begin
    if (!_rst) begin
      state_q <= S_IDLE;
      mag_a_q <= '0;
      mag_b_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef MULT_ACC_EN
      accm_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mag_a_q <= mag_a_d;
            mag_b_q <= {{SZ{1'b0}}, mag_b_d};
            neg_q   <= sgn & (a[SZ-1] ^ b[SZ-1]);
            acc_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
`ifdef MULT_ACC_EN
            accm_q  <= acc;
`endif
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q   <= acc_q + pp_d;
          mag_a_q <= mag_a_q >> K;
          mag_b_q <= mag_b_q << K;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= S_DONE;
        end
        S_DONE: begin
          res_q   <= res_d;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign res   = res_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: three SZ=8 instances with K=1, 2, 4 sharing operand inputs.
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a_v, b_v;
  logic        sgn_v;
  logic [2:0]  start_v;
  logic        acc_v;
  logic [15:0] res_w   [3];
  logic        ready_w [3];
  logic        done_w  [3];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mult_seq #(.SZ(8), .K(1)) u_k1 (
    .clk(clk), ._rst(rst_n), .a(a_v), .b(b_v), .sgn(sgn_v), .start(start_v[0]),
`ifdef MULT_ACC_EN
    .acc(acc_v),
`endif
    .res(res_w[0]), .ready(ready_w[0]), .done(done_w[0]));

  mult_seq #(.SZ(8), .K(2)) u_k2 (
    .clk(clk), ._rst(rst_n), .a(a_v), .b(b_v), .sgn(sgn_v), .start(start_v[1]),
`ifdef MULT_ACC_EN
    .acc(acc_v),
`endif
    .res(res_w[1]), .ready(ready_w[1]), .done(done_w[1]));

  mult_seq #(.SZ(8), .K(4)) u_k4 (
    .clk(clk), ._rst(rst_n), .a(a_v), .b(b_v), .sgn(sgn_v), .start(start_v[2]),
`ifdef MULT_ACC_EN
    .acc(acc_v),
`endif
    .res(res_w[2]), .ready(ready_w[2]), .done(done_w[2]));

  // Pulse start on one instance; lat = edges after acceptance until done seen (-1 on timeout).
  task automatic run_op(input int idx, input logic [7:0] av, input logic [7:0] bv,
                        input logic sv, input logic accv, output int lat);
    a_v = av; b_v = bv; sgn_v = sv; acc_v = accv;
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done_w[idx]) begin lat = i; break; end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      nvec++;
      if (res_w[i] !== 16'h0000 || ready_w[i] !== 1'b1 || done_w[i] !== 1'b0) begin
        nerr++;
        $display("FAIL reset[%0d]: got res=%h ready=%b done=%b, want res=0000 ready=1 done=0",
                 i, res_w[i], ready_w[i], done_w[i]);
      end
    end
  endtask

  task automatic test_k1_unsigned();
    int lat;
    run_op(0, 8'd3, 8'd5, 1'b0, 1'b0, lat);
    nvec++;
    if (lat !== 9 || res_w[0] !== 16'd15 || ready_w[0] !== 1'b1) begin
      nerr++;
      $display("FAIL k1_3x5: got lat=%0d res=%h ready=%b, want lat=9 res=000f ready=1",
               lat, res_w[0], ready_w[0]);
    end
    @(posedge clk); #1;
    nvec++;
    if (done_w[0] !== 1'b0 || res_w[0] !== 16'd15) begin
      nerr++;
      $display("FAIL k1_done_pulse: got done=%b res=%h, want done=0 res=000f", done_w[0], res_w[0]);
    end
    run_op(0, 8'h7F, 8'h80, 1'b1, 1'b0, lat);
    nvec++;
    if (lat !== 9 || res_w[0] !== 16'hC080) begin
      nerr++;
      $display("FAIL k1_127x-128: got lat=%0d res=%h, want lat=9 res=c080", lat, res_w[0]);
    end
    run_op(0, 8'hFF, 8'hFF, 1'b1, 1'b0, lat);
    nvec++;
    if (res_w[0] !== 16'h0001) begin
      nerr++;
      $display("FAIL k1_-1x-1: got res=%h, want res=0001", res_w[0]);
    end
    run_op(0, 8'hFF, 8'hFF, 1'b0, 1'b0, lat);
    nvec++;
    if (res_w[0] !== 16'hFE01) begin
      nerr++;
      $display("FAIL k1_255x255: got res=%h, want res=fe01", res_w[0]);
    end
  endtask

  task automatic test_k2_minneg();
    int lat;
    run_op(1, 8'h80, 8'h80, 1'b1, 1'b0, lat);
    nvec++;
    if (lat !== 5 || res_w[1] !== 16'h4000) begin
      nerr++;
      $display("FAIL k2_signed_minneg: got lat=%0d res=%h, want lat=5 res=4000", lat, res_w[1]);
    end
    run_op(1, 8'h80, 8'h80, 1'b0, 1'b0, lat);
    nvec++;
    if (lat !== 5 || res_w[1] !== 16'h4000) begin
      nerr++;
      $display("FAIL k2_unsigned_128: got lat=%0d res=%h, want lat=5 res=4000", lat, res_w[1]);
    end
  endtask

  task automatic test_k4_signed();
    int lat;
    run_op(2, 8'hFD, 8'd7, 1'b1, 1'b0, lat);
    nvec++;
    if (lat !== 3 || res_w[2] !== 16'hFFEB) begin
      nerr++;
      $display("FAIL k4_-3x7: got lat=%0d res=%h, want lat=3 res=ffeb", lat, res_w[2]);
    end
    run_op(2, 8'hFD, 8'd7, 1'b0, 1'b0, lat);
    nvec++;
    if (lat !== 3 || res_w[2] !== 16'h06EB) begin
      nerr++;
      $display("FAIL k4_253x7: got lat=%0d res=%h, want lat=3 res=06eb", lat, res_w[2]);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    a_v = 8'd2; b_v = 8'd2; sgn_v = 1'b0; acc_v = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a_v = 8'd9; b_v = 8'd9; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    lat = -1;
    for (int i = 5; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done_w[0]) begin lat = i; break; end
    end
    nvec++;
    if (lat !== 9 || res_w[0] !== 16'd4 || ready_w[0] !== 1'b1) begin
      nerr++;
      $display("FAIL midrun_ignore: got lat=%0d res=%h ready=%b, want lat=9 res=0004 ready=1",
               lat, res_w[0], ready_w[0]);
    end
    run_op(0, 8'd9, 8'd9, 1'b0, 1'b0, lat);
    nvec++;
    if (lat !== 9 || res_w[0] !== 16'd81) begin
      nerr++;
      $display("FAIL back_to_back: got lat=%0d res=%h, want lat=9 res=0051", lat, res_w[0]);
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    int seen;
    run_op(0, 8'd3, 8'd5, 1'b0, 1'b0, lat);
    nvec++;
    if (res_w[0] !== 16'd15) begin
      nerr++;
      $display("FAIL abort_pre: got res=%h, want res=000f", res_w[0]);
    end
    a_v = 8'd2; b_v = 8'd2; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    nvec++;
    if (res_w[0] !== 16'h0000 || ready_w[0] !== 1'b1 || done_w[0] !== 1'b0) begin
      nerr++;
      $display("FAIL abort_state: got res=%h ready=%b done=%b, want res=0000 ready=1 done=0",
               res_w[0], ready_w[0], done_w[0]);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done_w[0]) seen++;
    end
    nvec++;
    if (seen !== 0 || res_w[0] !== 16'h0000) begin
      nerr++;
      $display("FAIL abort_no_done: got done_pulses=%0d res=%h, want 0 and 0000", seen, res_w[0]);
    end
  endtask

`ifdef MULT_ACC_EN
  task automatic test_accumulate();
    int lat;
    do_reset();
    run_op(0, 8'd3, 8'd5, 1'b0, 1'b0, lat);
    nvec++;
    if (lat !== 9 || res_w[0] !== 16'd15) begin
      nerr++;
      $display("FAIL acc_first: got lat=%0d res=%h, want lat=9 res=000f", lat, res_w[0]);
    end
    run_op(0, 8'd2, 8'd4, 1'b0, 1'b1, lat);
    nvec++;
    if (lat !== 9 || res_w[0] !== 16'd23) begin
      nerr++;
      $display("FAIL acc_sum: got lat=%0d res=%h, want lat=9 res=0017", lat, res_w[0]);
    end
    run_op(0, 8'd255, 8'd255, 1'b0, 1'b0, lat);
    run_op(0, 8'd1, 8'd0, 1'b0, 1'b1, lat);
    run_op(0, 8'd255, 8'd1, 1'b0, 1'b1, lat);
    run_op(0, 8'd255, 8'd1, 1'b0, 1'b1, lat);
    nvec++;
    if (res_w[0] !== 16'hFFFF) begin
      nerr++;
      $display("FAIL acc_build_ffff: got res=%h, want res=ffff", res_w[0]);
    end
    run_op(0, 8'd1, 8'd1, 1'b0, 1'b1, lat);
    nvec++;
    if (res_w[0] !== 16'h0000) begin
      nerr++;
      $display("FAIL acc_wrap: got res=%h, want res=0000", res_w[0]);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; a_v = '0; b_v = '0; sgn_v = 1'b0; start_v = '0; acc_v = 1'b0;
    test_reset();
    test_k1_unsigned();
    test_k2_minneg();
    test_k4_signed();
    test_back_to_back();
    test_reset_abort();
`ifdef MULT_ACC_EN
    test_accumulate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
Parametrised multi-cycle shift-add multiplier. It replaces the single-cycle combinational multiplier where timing or area forbids a full SZ x SZ array in one cycle. It retires K multiplier bits per clock and supports signed and unsigned operands. It uses an explicit start/ready/done handshake, so bus-side wrappers (AXI4 and Avalon slaves) can launch an operation and poll for completion.

Parameters:
SZ, 32, operand width in bits; result is 2*SZ.
K, 1, multiplier bits consumed per cycle (radix 2^K); SZ % K == 0 required, checked by elaboration-time assertion.
STEPS (localparam), SZ/K, number of RUN cycles.

Ports:
clk  input  1  clock, all logic on rising edge.
_rst  input  1  synchronous active-low reset.
a  input  SZ  multiplicand; sampled only on an accepted start.
b  input  SZ  multiplier; sampled only on an accepted start.
sgn  input  1  1 = treat a, b as two's complement; sampled with start.
start  input  1  request; accepted only when ready=1.
res  output  2*SZ  product; registered; holds until the next completion or reset.
ready  output  1  1 = idle, can accept start.
done  output  1  single-cycle pulse, res valid and updated this cycle.

Behaviour:
- Reset (_rst=0 at a rising edge): state=IDLE, res=0, ready=1, done=0, all internal registers=0. This applies in any state; an operation in flight is abandoned and no done is produced.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE, start=1 at edge T0:
  - Latch mag_a=|a|, mag_b=|b| when sgn=1, else the raw operands.
  - Latch neg=sgn&(a[SZ-1]^b[SZ-1]); clear acc and cnt; ready<=0; go to RUN.
- RUN, per edge:
  - acc += mag_b_sh * mag_a[K-1:0] (2*SZ-bit add, no overflow possible).
  - mag_a >>= K; mag_b_sh <<= K; cnt++.
  - After STEPS RUN edges, go to DONE.
- DONE edge:
  - res <= neg ? -acc : acc (2*SZ-bit two's complement).
  - done<=1 for that cycle only; ready<=1; go to IDLE.
- Latency: start accepted at edge T0; done and new res visible after edge T0+STEPS+1. Fixed latency, no early termination on zero operands.
- start while ready=0: ignored; no queueing, no effect on the operation in flight.
- Back-to-back: start may be asserted in the cycle done=1, since ready=1 then. It is accepted at that edge; throughput is one result per STEPS+2 cycles.
- Width rules:
  - |-2^(SZ-1)| = 2^(SZ-1) fits in SZ unsigned bits, so the most negative operands are handled exactly.
  - sgn=0 with MSB set is treated as a large unsigned value.
- res changes only on a DONE edge or on reset; a/b/sgn changes after acceptance do not affect the result.

Optional Feature:
Macro MULT_ACC_EN.
- Defined:
  - Adds input port acc (1 bit), sampled with start.
  - acc=1: DONE writes res <= res + signed/unsigned product, 2*SZ-bit wrap-around, no saturation.
  - acc=0: plain product.
  - Reset clears res as usual, giving a known accumulator start.
- Undefined: port acc absent; res always the plain product. Latency is identical in both builds.

Test Plan:
- SZ=8, K=1, sgn=0, a=3, b=5, start pulsed at T0 -> done=1 in exactly one cycle after edge T0+9, res=16'd15, ready=1 in the same cycle.
- SZ=8, K=2, sgn=1, a=8'h80, b=8'h80 -> res=16'h4000 after STEPS+1=5 edges; same operands with sgn=0 -> res=16'h4000.
- SZ=8, K=4, sgn=1, a=-3 (8'hFD), b=7 -> res=16'hFFEB; with sgn=0 -> res=16'h06EB.
- Start accepted with a=2, b=2; a second start with a=9, b=9 issued mid-RUN -> ignored, res=4; then a new start in the done cycle with a=9, b=9 -> res=81 after STEPS+1 edges.
- _rst=0 for one edge during RUN after res previously held 15 -> next cycle res=0, ready=1, done=0; no done pulse ever for the aborted operation.
- MULT_ACC_EN, SZ=8: reset, then 3*5 (acc=0), then 2*4 (acc=1) -> res=15 then 23. Unsigned 16'hFFFF accumulate plus 1*1 -> res wraps to 16'h0000.
